// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style datapath controller: IF/ID/EX/MEM/WB sequencing
// with memory handshakes on mem_ready and a one-cycle retire pulse.

package multicycle_opcodes_pkg;
  localparam logic [6:0] OP_ARITHMETIC     = 7'b0110011;
  localparam logic [6:0] OP_ARITHMETIC_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD           = 7'b0000011;
  localparam logic [6:0] OP_STORE          = 7'b0100011;
  localparam logic [6:0] OP_BRANCH         = 7'b1100011;
  localparam logic [6:0] OP_JAL            = 7'b1101111;
  localparam logic [6:0] OP_JALR           = 7'b1100111;
  localparam logic [6:0] OP_ECALL          = 7'b1110011;
endpackage

// state | meaning
// IF    | fetch at PC, wait for mem_ready, load IR
// ID    | decode, ALUOut <= PC+imm; ECALL/unknown opcodes retire here
// EX    | execute; branches and jumps retire here
// MEM   | data access at ALUOut; STORE retires on mem_ready
// WB    | register writeback, PC <= PC+4
module multicycle_controller
  import multicycle_opcodes_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       bcond,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       pc_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       is_ecall,
  output logic       retire,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic       pc_write_c;
  logic [1:0] pc_source_c;
  logic       i_or_d_c;
  logic       mem_read_c;
  logic       mem_write_c;
  logic       ir_write_c;
  logic       reg_write_c;
  logic       mem_to_reg_c;
  logic       pc_to_reg_c;
  logic       alu_src_a_c;
  logic [1:0] alu_src_b_c;
  logic [1:0] alu_op_c;
  logic       is_ecall_c;
  logic       known_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  always_comb begin
    known_op = 1'b0;
    case (opcode)
      OP_ARITHMETIC, OP_ARITHMETIC_IMM, OP_LOAD, OP_STORE,
      OP_BRANCH, OP_JAL, OP_JALR, OP_ECALL: known_op = 1'b1;
      default:                              known_op = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = S_IF;
    pc_write_c   = 1'b0;
    pc_source_c  = 2'd0;
    i_or_d_c     = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    mem_to_reg_c = 1'b0;
    pc_to_reg_c  = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'd0;
    alu_op_c     = 2'd0;
    is_ecall_c   = 1'b0;

    case (state_q)
      S_IF: begin
        i_or_d_c   = 1'b0;
        mem_read_c = 1'b1;
        ir_write_c = mem_ready;
        state_d    = mem_ready ? S_ID : S_IF;
      end

      S_ID: begin
        alu_src_a_c = 1'b0;
        alu_src_b_c = 2'd2;
        alu_op_c    = 2'd0;
        if (opcode == OP_ECALL) begin
          is_ecall_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_IF;
        end else if (!known_op) begin
          // Unrecognised opcodes retire as a NOP rather than trapping.
          pc_write_c = 1'b1;
          state_d    = S_IF;
        end else begin
          state_d = S_EX;
        end
      end

      S_EX: begin
        case (opcode)
          OP_ARITHMETIC: begin
            alu_src_a_c = 1'b1;
            alu_src_b_c = 2'd0;
            alu_op_c    = 2'd2;
            state_d     = S_WB;
          end
          OP_ARITHMETIC_IMM: begin
            alu_src_a_c = 1'b1;
            alu_src_b_c = 2'd2;
            alu_op_c    = 2'd2;
            state_d     = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a_c = 1'b1;
            alu_src_b_c = 2'd2;
            alu_op_c    = 2'd0;
            state_d     = S_MEM;
          end
          OP_BRANCH: begin
            // Branch target was computed in ID and sits in ALUOut.
            alu_src_a_c = 1'b1;
            alu_src_b_c = 2'd0;
            alu_op_c    = 2'd1;
            pc_write_c  = 1'b1;
            pc_source_c = bcond ? 2'd1 : 2'd0;
            state_d     = S_IF;
          end
          OP_JAL: begin
            pc_write_c  = 1'b1;
            pc_source_c = 2'd1;
            reg_write_c = 1'b1;
            pc_to_reg_c = 1'b1;
            state_d     = S_IF;
          end
          OP_JALR: begin
            alu_src_a_c = 1'b1;
            alu_src_b_c = 2'd2;
            alu_op_c    = 2'd0;
            pc_write_c  = 1'b1;
            pc_source_c = 2'd2;
            reg_write_c = 1'b1;
            pc_to_reg_c = 1'b1;
            state_d     = S_IF;
          end
          default: state_d = S_IF;
        endcase
      end

      S_MEM: begin
        if (opcode == OP_LOAD) begin
          i_or_d_c   = 1'b1;
          mem_read_c = 1'b1;
          state_d    = mem_ready ? S_WB : S_MEM;
        end else if (opcode == OP_STORE) begin
          i_or_d_c    = 1'b1;
          mem_write_c = 1'b1;
          pc_write_c  = mem_ready;
          state_d     = mem_ready ? S_IF : S_MEM;
        end else begin
          state_d = S_IF;
        end
      end

      S_WB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = (opcode == OP_LOAD);
        pc_write_c   = 1'b1;
        pc_source_c  = 2'd0;
        state_d      = S_IF;
      end

      default: state_d = S_IF;
    endcase
  end

  // Reset masks every request combinationally so an in-flight access
  // is dropped in the same cycle, not at the next edge.
  always_comb begin
    pc_write   = ~reset & pc_write_c;
    pc_source  = reset ? 2'd0 : pc_source_c;
    i_or_d     = ~reset & i_or_d_c;
    mem_read   = ~reset & mem_read_c;
    mem_write  = ~reset & mem_write_c;
    ir_write   = ~reset & ir_write_c;
    reg_write  = ~reset & reg_write_c;
    mem_to_reg = ~reset & mem_to_reg_c;
    pc_to_reg  = ~reset & pc_to_reg_c;
    alu_src_a  = ~reset & alu_src_a_c;
    alu_src_b  = reset ? 2'd0 : alu_src_b_c;
    alu_op     = reset ? 2'd0 : alu_op_c;
    is_ecall   = ~reset & is_ecall_c;
    retire     = ~reset & pc_write_c;
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller: per-cycle rows of
// inputs and hand-computed state/outputs, plus an async-reset-mid-store case.
`timescale 1ns/1ps
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       bcond;
  logic       mem_ready;
  logic       pc_write;
  logic [1:0] pc_source;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_to_reg;
  logic       pc_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       is_ecall;
  logic       retire;
  logic [2:0] state;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .pc_to_reg(pc_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .is_ecall(is_ecall), .retire(retire), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] ADD   = 7'b0110011;
  localparam logic [6:0] ADDI  = 7'b0010011;
  localparam logic [6:0] LD    = 7'b0000011;
  localparam logic [6:0] ST    = 7'b0100011;
  localparam logic [6:0] BR    = 7'b1100011;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] ECALL = 7'b1110011;
  localparam logic [6:0] NOP0  = 7'b0000000;
  localparam logic [6:0] FENCE = 7'b0001111;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       pc_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       is_ecall;
    logic       retire;
  } outs_t;

  typedef struct packed {
    logic [6:0] op;
    logic       bc;
    logic       mr;
    logic [2:0] st;
    outs_t      exp;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  outs_t E_ZERO, E_IF0, E_IF1, E_ID, E_ID_RET, E_ID_ECALL;
  outs_t E_EX_R, E_EX_I, E_EX_MEM, E_EX_BR1, E_EX_BR0, E_JAL, E_JALR;
  outs_t E_MEM_LD, E_MEM_ST0, E_MEM_ST1, E_WB_R, E_WB_LD;

  function automatic outs_t get_outs();
    outs_t o;
    o.pc_write   = pc_write;
    o.pc_source  = pc_source;
    o.i_or_d     = i_or_d;
    o.mem_read   = mem_read;
    o.mem_write  = mem_write;
    o.ir_write   = ir_write;
    o.reg_write  = reg_write;
    o.mem_to_reg = mem_to_reg;
    o.pc_to_reg  = pc_to_reg;
    o.alu_src_a  = alu_src_a;
    o.alu_src_b  = alu_src_b;
    o.alu_op     = alu_op;
    o.is_ecall   = is_ecall;
    o.retire     = retire;
    return o;
  endfunction

  task automatic check(input string name, input logic [2:0] st_exp, input outs_t e);
    outs_t a;
    a = get_outs();
    total++;
    if (state === st_exp) passed++;
    else $display("FAIL %s state: got %0d want %0d", name, state, st_exp);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s outputs: got %h want %h", name, a, e);
  endtask

  task automatic add(input logic [6:0] op, input logic bc, input logic mr,
                     input logic [2:0] st, input outs_t e);
    vec_t v;
    v.op = op; v.bc = bc; v.mr = mr; v.st = st; v.exp = e;
    vecs.push_back(v);
  endtask

  // Called at a negedge: drive, let comb logic settle, check, move to next negedge.
  task automatic run_row(input string name, input vec_t v);
    opcode    = v.op;
    bcond     = v.bc;
    mem_ready = v.mr;
    #1;
    check(name, v.st, v.exp);
    @(negedge clk);
  endtask

  initial begin
    E_ZERO = '0;
    E_IF0 = '0; E_IF0.mem_read = 1'b1;
    E_IF1 = E_IF0; E_IF1.ir_write = 1'b1;
    E_ID = '0; E_ID.alu_src_b = 2'd2;
    E_ID_RET = E_ID; E_ID_RET.pc_write = 1'b1; E_ID_RET.retire = 1'b1;
    E_ID_ECALL = E_ID_RET; E_ID_ECALL.is_ecall = 1'b1;
    E_EX_R = '0; E_EX_R.alu_src_a = 1'b1; E_EX_R.alu_op = 2'd2;
    E_EX_I = E_EX_R; E_EX_I.alu_src_b = 2'd2;
    E_EX_MEM = '0; E_EX_MEM.alu_src_a = 1'b1; E_EX_MEM.alu_src_b = 2'd2;
    E_EX_BR0 = '0; E_EX_BR0.alu_src_a = 1'b1; E_EX_BR0.alu_op = 2'd1;
    E_EX_BR0.pc_write = 1'b1; E_EX_BR0.retire = 1'b1;
    E_EX_BR1 = E_EX_BR0; E_EX_BR1.pc_source = 2'd1;
    E_JAL = '0; E_JAL.pc_write = 1'b1; E_JAL.pc_source = 2'd1;
    E_JAL.reg_write = 1'b1; E_JAL.pc_to_reg = 1'b1; E_JAL.retire = 1'b1;
    E_JALR = E_EX_MEM; E_JALR.pc_write = 1'b1; E_JALR.pc_source = 2'd2;
    E_JALR.reg_write = 1'b1; E_JALR.pc_to_reg = 1'b1; E_JALR.retire = 1'b1;
    E_MEM_LD = '0; E_MEM_LD.i_or_d = 1'b1; E_MEM_LD.mem_read = 1'b1;
    E_MEM_ST0 = '0; E_MEM_ST0.i_or_d = 1'b1; E_MEM_ST0.mem_write = 1'b1;
    E_MEM_ST1 = E_MEM_ST0; E_MEM_ST1.pc_write = 1'b1; E_MEM_ST1.retire = 1'b1;
    E_WB_R = '0; E_WB_R.reg_write = 1'b1; E_WB_R.pc_write = 1'b1; E_WB_R.retire = 1'b1;
    E_WB_LD = E_WB_R; E_WB_LD.mem_to_reg = 1'b1;

    // ADD: IF, ID, EX, WB
    add(ADD, 0, 1, 0, E_IF1); add(ADD, 0, 1, 1, E_ID);
    add(ADD, 0, 1, 2, E_EX_R); add(ADD, 0, 1, 4, E_WB_R);
    // ADDI with one fetch wait cycle
    add(ADDI, 0, 0, 0, E_IF0); add(ADDI, 0, 1, 0, E_IF1); add(ADDI, 0, 1, 1, E_ID);
    add(ADDI, 0, 1, 2, E_EX_I); add(ADDI, 0, 1, 4, E_WB_R);
    // LOAD with two MEM wait cycles; mem_ready low in WB ignored
    add(LD, 0, 1, 0, E_IF1); add(LD, 0, 1, 1, E_ID); add(LD, 0, 1, 2, E_EX_MEM);
    add(LD, 0, 0, 3, E_MEM_LD); add(LD, 0, 0, 3, E_MEM_LD); add(LD, 0, 1, 3, E_MEM_LD);
    add(LD, 0, 0, 4, E_WB_LD);
    // BRANCH taken, then not taken with mem_ready low in ID/EX
    add(BR, 1, 1, 0, E_IF1); add(BR, 1, 1, 1, E_ID); add(BR, 1, 1, 2, E_EX_BR1);
    add(BR, 0, 1, 0, E_IF1); add(BR, 0, 0, 1, E_ID); add(BR, 0, 0, 2, E_EX_BR0);
    // JAL, JALR
    add(JAL, 0, 1, 0, E_IF1); add(JAL, 0, 1, 1, E_ID); add(JAL, 0, 1, 2, E_JAL);
    add(JALR, 0, 1, 0, E_IF1); add(JALR, 0, 1, 1, E_ID); add(JALR, 0, 1, 2, E_JALR);
    // ECALL, opcode 0, unsupported opcode: all retire from ID
    add(ECALL, 0, 1, 0, E_IF1); add(ECALL, 0, 1, 1, E_ID_ECALL);
    add(NOP0, 0, 1, 0, E_IF1); add(NOP0, 0, 1, 1, E_ID_RET);
    add(FENCE, 0, 1, 0, E_IF1); add(FENCE, 0, 1, 1, E_ID_RET);
    // STORE with one MEM wait cycle, then the next fetch
    add(ST, 0, 1, 0, E_IF1); add(ST, 0, 1, 1, E_ID); add(ST, 0, 1, 2, E_EX_MEM);
    add(ST, 0, 0, 3, E_MEM_ST0); add(ST, 0, 1, 3, E_MEM_ST1); add(ST, 0, 1, 0, E_IF1);

    // Reset held: outputs zero even with mem_ready high in IF
    reset = 1'b1; opcode = ADD; bcond = 1'b0; mem_ready = 1'b1;
    #3;
    check("reset_hold", 3'd0, E_ZERO);
    @(negedge clk);
    #1;
    check("reset_hold_edge", 3'd0, E_ZERO);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      run_row($sformatf("row%0d", i), vecs[i]);

    // Store re-entered from ID; stall in MEM then reset asynchronously.
    begin
      vec_t v;
      v.op = ST; v.bc = 0; v.mr = 1; v.st = 3'd1; v.exp = E_ID;
      run_row("st2_id", v);
      v.st = 3'd2; v.exp = E_EX_MEM;
      run_row("st2_ex", v);
      v.mr = 0; v.st = 3'd3; v.exp = E_MEM_ST0;
      run_row("st2_mem", v);
    end
    #1;
    check("st2_mem_stall", 3'd3, E_MEM_ST0);
    #1;
    reset = 1'b1;
    #1;
    check("async_reset_mid_store", 3'd0, E_ZERO);
    @(negedge clk);
    #1;
    check("reset_after_edge", 3'd0, E_ZERO);
    mem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("first_fetch", 3'd0, E_IF1);
    @(posedge clk);
    #1;
    check("first_fetch_to_id", 3'd1, E_ID);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  7  opcode field of the instruction register; stable from ID until the next IF.
- bcond  in  1  branch condition from the ALU, valid in EX for BRANCH.
- mem_ready  in  1  memory done strobe; the access completes on a rising edge where this is 1.
- pc_write  out  1  load PC.
- pc_source  out  2  PC input select: 0 = PC+4 (dedicated adder), 1 = ALUOut register, 2 = ALU result.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  load instruction register.
- reg_write  out  1  register file write enable.
- mem_to_reg  out  1  writeback select: 1 = MDR, 0 = ALUOut.
- pc_to_reg  out  1  writeback select: PC+4 (overrides mem_to_reg).
- alu_src_a  out  1  0 = PC, 1 = rs1.
- alu_src_b  out  2  0 = rs2, 2 = immediate; 1 and 3 are unused and never driven.
- alu_op  out  2  0 = ADD, 1 = branch compare, 2 = funct decode.
- is_ecall  out  1  ECALL detected.
- retire  out  1  one-cycle pulse when an instruction completes.
- state  out  3  current state, for debug.
REQ-002 Opcode constants SHALL come from the shared opcode definitions.

Function
REQ-003 The state encoding SHALL be IF=0, ID=1, EX=2, MEM=3, WB=4; codes 5-7 SHALL go to IF on the next edge.
REQ-004 Any output not listed for a state SHALL be 0; outputs are combinational from state, opcode, bcond and mem_ready.
REQ-005 In IF: i_or_d=0, mem_read=1, ir_write=mem_ready; the next state is ID if mem_ready=1, otherwise IF.
REQ-006 In ID: alu_src_a=0, alu_src_b=2, alu_op=0, so PC+imm is latched into ALUOut.
REQ-007 ID with ECALL: is_ecall=1, pc_write=1, pc_source=0, retire=1; next state IF.
REQ-008 ID with an opcode outside {ARITHMETIC, ARITHMETIC_IMM, LOAD, STORE, BRANCH, JAL, JALR, ECALL} SHALL be treated as a NOP: pc_write=1, pc_source=0, retire=1; next state IF.
REQ-009 ID with any other opcode SHALL go to EX.
REQ-010 In EX for ARITHMETIC: alu_src_a=1, alu_src_b=0, alu_op=2; next state WB.
REQ-011 In EX for ARITHMETIC_IMM: alu_src_a=1, alu_src_b=2, alu_op=2; next state WB.
REQ-012 In EX for LOAD or STORE: alu_src_a=1, alu_src_b=2, alu_op=0; next state MEM.
REQ-013 In EX for BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write=1, pc_source=bcond?1:0, retire=1; next state IF.
REQ-014 In EX for JAL: pc_write=1, pc_source=1, reg_write=1, pc_to_reg=1, retire=1; next state IF.
REQ-015 In EX for JALR: alu_src_a=1, alu_src_b=2, alu_op=0, pc_write=1, pc_source=2, reg_write=1, pc_to_reg=1, retire=1; next state IF.
REQ-016 In MEM for LOAD: i_or_d=1, mem_read=1; next state WB if mem_ready=1, otherwise stay in MEM.
REQ-017 In MEM for STORE: i_or_d=1, mem_write=1; when mem_ready=1 also pc_write=1, pc_source=0, retire=1, and the next state is IF; otherwise stay in MEM with pc_write=0.
REQ-018 In WB: reg_write=1, mem_to_reg=(opcode==LOAD), pc_write=1, pc_source=0, retire=1; next state IF.
REQ-019 Latency SHALL be, with zero memory wait: ALU ops 4 cycles, LOAD 5, STORE 4, BRANCH/JAL/JALR 3, ECALL/NOP 2.
REQ-020 Each cycle mem_ready is low in IF or MEM SHALL add exactly one cycle.
REQ-021 mem_ready outside IF and MEM SHALL be ignored.
REQ-022 mem_read and mem_write SHALL never both be 1.
REQ-023 retire SHALL equal pc_write in every cycle.

Reset
REQ-024 When reset is asserted, state SHALL become IF immediately, without waiting for clk.
REQ-025 While reset is high, every output other than state SHALL be 0, including mem_read.
REQ-026 Reset asserted mid-instruction (for example in MEM with mem_write=1) SHALL drop all requests in the same cycle, with no PC or register write.
REQ-027 The first fetch SHALL begin on the first rising edge after reset deasserts.

Verification
REQ-028 ADD (opcode 0110011), mem_ready held at 1 -> states 0,1,2,4,0; reg_write=1 only in cycle 4; retire pulses once.
REQ-029 LOAD with mem_ready low for 2 cycles in MEM -> MEM lasts 3 cycles with mem_read=1 and i_or_d=1; WB then has mem_to_reg=1.
REQ-030 BRANCH with bcond=1, then bcond=0 -> EX shows pc_source=1, then pc_source=0; reg_write stays 0 both times.
REQ-031 JALR -> in EX, pc_source=2, pc_to_reg=1, reg_write=1; next state IF.
REQ-032 ECALL, then opcode 0000000 -> each gives a 2-cycle sequence IF,ID; is_ecall=1 only for ECALL.
REQ-033 Assert reset asynchronously mid-STORE in MEM -> mem_write drops before the next edge; state=0; no pc_write.
